// File: rtl/calculator_pkg.sv
// Shared calculator types: ALU opcode encoding and the ALU arbiter state encoding.
package calculator_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE  = 2'b01,
    S_WAIT   = 2'b10,
    S_RETURN = 2'b11
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two ALU requesters, the arbiter and the shared ALU.
// Every channel is valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; valid must not wait on ready, and payload
// must stay stable while valid is high and ready is low.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] i_req0_a, i_req0_b;
  logic [1:0]            i_req0_op;
  logic                  i_req0_signed, i_req0_valid, o_req0_ready;
  logic [DATA_WIDTH-1:0] o_req0_result;
  logic                  o_req0_error, o_req0_result_valid, i_req0_result_ready;

  logic [DATA_WIDTH-1:0] i_req1_a, i_req1_b;
  logic [1:0]            i_req1_op;
  logic                  i_req1_signed, i_req1_valid, o_req1_ready;
  logic [DATA_WIDTH-1:0] o_req1_result;
  logic                  o_req1_error, o_req1_result_valid, i_req1_result_ready;

  logic [DATA_WIDTH-1:0] o_alu_input_a, o_alu_input_b;
  logic [1:0]            o_alu_input_op;
  logic                  o_alu_input_signed, o_alu_input_valid, i_alu_input_ready;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_alu_error, i_alu_result_valid, o_alu_result_ready;

  modport slave (
    input  i_req0_a, i_req0_b, i_req0_op, i_req0_signed, i_req0_valid, i_req0_result_ready,
    output o_req0_ready, o_req0_result, o_req0_error, o_req0_result_valid,
    input  i_req1_a, i_req1_b, i_req1_op, i_req1_signed, i_req1_valid, i_req1_result_ready,
    output o_req1_ready, o_req1_result, o_req1_error, o_req1_result_valid,
    output o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed, o_alu_input_valid,
    input  i_alu_input_ready, i_alu_result, i_alu_error, i_alu_result_valid,
    output o_alu_result_ready
  );

  modport master (
    output i_req0_a, i_req0_b, i_req0_op, i_req0_signed, i_req0_valid, i_req0_result_ready,
    input  o_req0_ready, o_req0_result, o_req0_error, o_req0_result_valid,
    output i_req1_a, i_req1_b, i_req1_op, i_req1_signed, i_req1_valid, i_req1_result_ready,
    input  o_req1_ready, o_req1_result, o_req1_error, o_req1_result_valid,
    input  o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed, o_alu_input_valid,
    output i_alu_input_ready, i_alu_result, i_alu_error, i_alu_result_valid,
    input  o_alu_result_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one transaction
// in flight at a time: accept, issue to ALU, wait for result, hand back.
module alu_arbiter
  import calculator_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus,
  output logic        o_busy,
  output arb_state_e  o_state
);

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic                  sgn_q, sgn_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  error_q, error_d;
  logic                  grant_vld, grant;

  // On a tie the requester that did not own the last transaction wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 1'b0;
    if (bus.i_req0_valid && bus.i_req1_valid) begin
      grant_vld = 1'b1;
      grant     = ~last_grant_q;
    end else if (bus.i_req0_valid) begin
      grant_vld = 1'b1;
      grant     = 1'b0;
    end else if (bus.i_req1_valid) begin
      grant_vld = 1'b1;
      grant     = 1'b1;
    end
  end

  assign bus.o_req0_ready = (state_q == S_IDLE) & grant_vld & ~grant;
  assign bus.o_req1_ready = (state_q == S_IDLE) & grant_vld &  grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    sgn_d        = sgn_q;
    result_d     = result_q;
    error_d      = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = S_ISSUE;
          owner_d = grant;
          a_d     = grant ? bus.i_req1_a      : bus.i_req0_a;
          b_d     = grant ? bus.i_req1_b      : bus.i_req0_b;
          op_d    = grant ? bus.i_req1_op     : bus.i_req0_op;
          sgn_d   = grant ? bus.i_req1_signed : bus.i_req0_signed;
        end
      end
      S_ISSUE: begin
        if (bus.i_alu_input_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_alu_result_valid) begin
          state_d  = S_RETURN;
          result_d = bus.i_alu_result;
          error_d  = bus.i_alu_error;
        end
      end
      S_RETURN: begin
        if (owner_q ? bus.i_req1_result_ready : bus.i_req0_result_ready) begin
          state_d      = S_IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      sgn_q        <= 1'b0;
      result_q     <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      sgn_q        <= sgn_d;
      result_q     <= result_d;
      error_q      <= error_d;
    end
  end

  // Registered operands/result drive the buses directly so they hold under backpressure.
  assign bus.o_alu_input_a       = a_q;
  assign bus.o_alu_input_b       = b_q;
  assign bus.o_alu_input_op      = op_q;
  assign bus.o_alu_input_signed  = sgn_q;
  assign bus.o_alu_input_valid   = (state_q == S_ISSUE);
  assign bus.o_alu_result_ready  = (state_q == S_WAIT);

  assign bus.o_req0_result       = result_q;
  assign bus.o_req0_error        = error_q;
  assign bus.o_req0_result_valid = (state_q == S_RETURN) & ~owner_q;
  assign bus.o_req1_result       = result_q;
  assign bus.o_req1_error        = error_q;
  assign bus.o_req1_result_valid = (state_q == S_RETURN) &  owner_q;

  assign o_busy  = (state_q != S_IDLE);
  assign o_state = state_q;

endmodule
